// File: rtl/score_pkg.sv
// Shared types and constants for the score counter and its display stage.
package score_pkg;

    localparam int unsigned COUNT_W   = 7;
    localparam int unsigned DISP_W    = 16;
    localparam int unsigned DIGIT_MAX = 99;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        REPEAT
    } rep_state_t;

    // Clear wins, opposing steps cancel, otherwise saturate at 0 and max.
    function automatic logic [COUNT_W-1:0] next_count(
        input logic [COUNT_W-1:0] cur,
        input logic [COUNT_W-1:0] max,
        input logic               clr,
        input logic               up,
        input logic               dn
    );
        logic [COUNT_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (up && dn) begin
            nxt = cur;
        end else if (up) begin
            if (cur < max) nxt = cur + COUNT_W'(1);
        end else if (dn) begin
            if (cur != '0) nxt = cur - COUNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchroniser, debounce filter and one-cycle rising-edge press pulse for one button.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/score_counter.sv
// Saturating 0..MAX_COUNT push-button counter feeding the two-digit display.
// Optional auto-repeat on held up/down buttons: define SCORE_COUNTER_AUTO_REPEAT_EN.
module score_counter
    import score_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_COUNT       = 99,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_clear,
    output logic [DISP_W-1:0] count,
    output logic              updated,
    output logic              at_max,
    output logic              at_min
);

    if (MAX_COUNT > DIGIT_MAX) begin : g_max_check
        $error("MAX_COUNT must not exceed DIGIT_MAX");
    end

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

    logic               up_lvl, dn_lvl, clr_lvl;
    logic               up_p, dn_p, clr_p;
    logic               up_step_c, dn_step_c;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_next_c;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clock(clock), .reset(reset), .btn(btn_up),    .level(up_lvl),  .press(up_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clock(clock), .reset(reset), .btn(btn_down),  .level(dn_lvl),  .press(dn_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock(clock), .reset(reset), .btn(btn_clear), .level(clr_lvl), .press(clr_p)
    );

`ifdef SCORE_COUNTER_AUTO_REPEAT_EN
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [1:0]       dir_lvl;
    logic [1:0]       dir_press;
    rep_state_t       st_q   [2];
    rep_state_t       st_d   [2];
    logic [TMR_W-1:0] tmr_q  [2];
    logic [TMR_W-1:0] tmr_d  [2];
    logic [1:0]       rep_q;
    logic [1:0]       rep_d;
    logic             unused_lvl;

    assign dir_lvl    = {dn_lvl, up_lvl};
    assign dir_press  = {dn_p, up_p};
    assign unused_lvl = clr_lvl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                st_q[d]  <= IDLE;
                tmr_q[d] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                st_q[d]  <= st_d[d];
                tmr_q[d] <= tmr_d[d];
            end
            rep_q <= rep_d;
        end
    end

    // Per-direction repeat FSM; index 0 is up, 1 is down.
    always_comb begin
        rep_d = '0;
        for (int d = 0; d < 2; d++) begin
            st_d[d]  = st_q[d];
            tmr_d[d] = tmr_q[d];
            if (clr_p || !dir_lvl[d]) begin
                st_d[d]  = IDLE;
                tmr_d[d] = '0;
            end else begin
                case (st_q[d])
                    IDLE: begin
                        if (dir_press[d]) begin
                            st_d[d]  = HOLD_WAIT;
                            tmr_d[d] = '0;
                        end
                    end
                    HOLD_WAIT: begin
                        if (tmr_q[d] == TMR_W'(REPEAT_DELAY - 1)) begin
                            st_d[d]  = REPEAT;
                            tmr_d[d] = '0;
                        end else begin
                            tmr_d[d] = tmr_q[d] + TMR_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (tmr_q[d] == TMR_W'(REPEAT_PERIOD - 1)) begin
                            rep_d[d] = 1'b1;
                            tmr_d[d] = '0;
                        end else begin
                            tmr_d[d] = tmr_q[d] + TMR_W'(1);
                        end
                    end
                    default: begin
                        st_d[d]  = IDLE;
                        tmr_d[d] = '0;
                    end
                endcase
            end
        end
    end

    assign up_step_c = up_p | rep_q[0];
    assign dn_step_c = dn_p | rep_q[1];
`else
    logic unused_lvl;

    assign unused_lvl = ^{up_lvl, dn_lvl, clr_lvl, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign up_step_c  = up_p;
    assign dn_step_c  = dn_p;
`endif

    assign cnt_next_c = next_count(cnt_q, MAX_C, clr_p, up_step_c, dn_step_c);

    // Flags are derived from the next value so they line up with count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            updated <= 1'b0;
            at_max  <= 1'b0;
            at_min  <= 1'b1;
        end else begin
            cnt_q   <= cnt_next_c;
            updated <= (cnt_next_c != cnt_q);
            at_max  <= (cnt_next_c == MAX_C);
            at_min  <= (cnt_next_c == '0);
        end
    end

    assign count = DISP_W'(cnt_q);

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: vector table plus hand sequences, scoreboard on updated.
module tb_score_counter;

    localparam int MAXC = 99;
`ifdef SCORE_COUNTER_AUTO_REPEAT_EN
    localparam int HOLD = 6;
`else
    localparam int HOLD = 20;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] count;
    logic        updated;
    logic        at_max;
    logic        at_min;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int upd_seen = 0;
    bit sb_en    = 1'b1;
    int model    = 0;

    typedef struct {
        bit u;
        bit d;
        bit c;
        int hold;
        int exp;
    } vec_t;

    vec_t vecs[10];

    score_counter dut (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clear(btn_clear), .count(count), .updated(updated),
        .at_max(at_max), .at_min(at_min)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Every updated pulse must match the next queued expected count.
    always @(negedge clock) begin
        if (!reset && updated && sb_en) begin
            int e;
            upd_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_update", int'(count), -1);
            end else begin
                e = exp_q.pop_front();
                check("sb_count", int'(count), e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit u, input bit d, input bit c, input int hold, input int gap);
        btn_up = u; btn_down = d; btn_clear = c;
        tick(hold);
        btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0;
        tick(gap);
    endtask

    function automatic int model_next(input int cur, input bit u, input bit d, input bit c);
        if (c) return 0;
        if (u && d) return cur;
        if (u) return (cur < MAXC) ? cur + 1 : cur;
        if (d) return (cur > 0) ? cur - 1 : cur;
        return cur;
    endfunction

    task automatic apply_model(input bit u, input bit d, input bit c, input int hold);
        int nxt;
        nxt = model_next(model, u, d, c);
        if (nxt != model) exp_q.push_back(nxt);
        model = nxt;
        drive(u, d, c, hold, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        vecs[0] = '{1, 0, 0, HOLD, 2};
        vecs[1] = '{1, 0, 0, HOLD, 3};
        vecs[2] = '{1, 0, 0, 3,    3};
        vecs[3] = '{0, 1, 0, 6,    2};
        vecs[4] = '{0, 0, 1, 6,    0};
        vecs[5] = '{0, 0, 1, 6,    0};
        vecs[6] = '{0, 1, 0, 6,    0};
        vecs[7] = '{1, 1, 0, 6,    0};
        vecs[8] = '{1, 0, 0, 6,    1};
        vecs[9] = '{1, 0, 1, 6,    0};

        tick(3);
        check("rst_count", int'(count), 0);
        check("rst_at_min", int'(at_min), 1);
        check("rst_at_max", int'(at_max), 0);
        check("rst_updated", int'(updated), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick(10);
            check("idle_count", int'(count), 0);
            check("idle_at_min", int'(at_min), 1);
        end

        // First press: cycle-exact latency from the first sampling edge.
        exp_q.push_back(1);
        btn_up = 1'b1;
        tick(7);
        check("lat_before", int'(count), 0);
        tick(1);
        check("lat_after", int'(count), 1);
        tick(HOLD - 8);
        btn_up = 1'b0;
        tick(12);
        model = 1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].exp != model) exp_q.push_back(vecs[i].exp);
            model = vecs[i].exp;
            drive(vecs[i].u, vecs[i].d, vecs[i].c, vecs[i].hold, 12);
            check("vec_count", int'(count), vecs[i].exp);
            check("vec_at_min", int'(at_min), int'(vecs[i].exp == 0));
            check("vec_at_max", int'(at_max), int'(vecs[i].exp == MAXC));
            if (i == 2) check("three_pulses", upd_seen, 3);
        end

        // Preload to the ceiling and test saturation.
        apply_model(0, 0, 1, 6);
        for (int i = 0; i < 99; i++) apply_model(1, 0, 0, 6);
        check("pre_count", int'(count), 99);
        check("pre_at_max", int'(at_max), 1);
        snap = upd_seen;
        apply_model(1, 0, 0, 6);
        check("sat_count", int'(count), 99);
        check("sat_at_max", int'(at_max), 1);
        check("sat_no_pulse", upd_seen, snap);
        apply_model(0, 1, 0, 6);
        check("down_count", int'(count), 98);
        check("down_at_max", int'(at_max), 0);

        // Simultaneous up/down cancels; clear beats up.
        apply_model(0, 0, 1, 6);
        for (int i = 0; i < 5; i++) apply_model(1, 0, 0, 6);
        check("five_count", int'(count), 5);
        snap = upd_seen;
        apply_model(1, 1, 0, 6);
        check("updn_count", int'(count), 5);
        check("updn_no_pulse", upd_seen, snap);
        apply_model(1, 0, 1, 6);
        check("clrup_count", int'(count), 0);

        // Reset mid-press discards the press; held button must re-qualify.
        apply_model(1, 0, 0, 6);
        btn_up = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_at_min", int'(at_min), 1);
        check("midrst_updated", int'(updated), 0);
        tick(3);
        reset = 1'b0;
        exp_q.push_back(1);
        tick(7);
        check("requal_before", int'(count), 0);
        tick(1);
        check("requal_after", int'(count), 1);
        btn_up = 1'b0;
        tick(12);
        model = 1;

`ifdef SCORE_COUNTER_AUTO_REPEAT_EN
        apply_model(0, 0, 1, 6);
        sb_en = 1'b0;
        btn_up = 1'b1;
        tick(40);
        check("repeat_steps", int'(count >= 2), 1);
        reset = 1'b1;
        #1;
        check("repeat_rst_count", int'(count), 0);
        btn_up = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(12);
        check("repeat_idle_count", int'(count), 0);
        sb_en = 1'b1;
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
